pipe_hazard_unit: RTL and testbench
===================================

Name: pipe_hazard_unit

Overview:
- Parametrised hazard and forwarding controller for the 5-stage pipeline (IF, ID, EX, MEM, WB).
- Shadows destination/control info for the EX, MEM and WB stages in its own tracking registers.
- Generates load-use stall, branch flush and EX-stage forwarding selects. Freezes together with the pipeline on a cache miss (inp_hit=0).
- Adds saturating stall/flush event counters for performance debug.

Parameters:
- REG_AW, 3, register-address width.
- CNT_W, 16, width of each event counter.
- ZERO_REG_HARD, 1, when 1 register 0 never causes a hazard or forward.

Ports:
- inp_clk  input  1  pipeline clock (slow clock domain)
- inp_rst  input  1  asynchronous active-high reset
- inp_hit  input  1  instruction fetch hit; 0 freezes all tracking state and counters
- inp_pcSrc  input  1  branch taken, resolved in MEM stage
- inp_id_valid  input  1  ID stage holds a real instruction
- inp_id_rs  input  REG_AW  ID source register A
- inp_id_rt  input  REG_AW  ID source register B
- inp_id_useRs  input  1  ID instruction reads rs
- inp_id_useRt  input  1  ID instruction reads rt
- inp_id_dest  input  REG_AW  ID destination (after regDst mux)
- inp_id_regWrite  input  1  ID instruction writes a register
- inp_id_memRead  input  1  ID instruction is a load
- out_stall  output  1  hold PC and IF_ID; insert bubble into ID_EX
- out_flush  output  1  clear IF_ID, ID_EX, EX_MEM control bits
- out_fwdA  output  2  EX operand A source: 00 regfile, 01 EX_MEM aluResult, 10 MEM_RB write data
- out_fwdB  output  2  same encoding for operand B
- out_idBypassA  output  1  WB writes the register ID reads on rs this cycle
- out_idBypassB  output  1  same for rt
- out_stallCount  output  CNT_W  saturating count of stall cycles
- out_flushCount  output  CNT_W  saturating count of flush events

Behaviour:
- Tracking stages: EX holds {valid, rs, rt, useRs, useRt, dest, regWrite, memRead}. MEM and WB hold {valid, dest, regWrite, memRead}.
- A stage "writes r" when valid & regWrite & dest==r, and additionally dest!=0 if ZERO_REG_HARD.
- Reset (async, immediate): all valid bits 0, counters 0. out_stall, out_flush, out_idBypassA/B are 0; out_fwdA/B are 00.
- Load-use (combinational): out_stall = inp_hit & ~inp_pcSrc & inp_id_valid & EX.valid & EX.memRead & EX writes r, where r matches (useRs & rs) or (useRt & rt).
- out_flush = inp_hit & inp_pcSrc. Flush has priority over stall.
- Clock edge with inp_hit=0: every tracking register and counter holds.
- Clock edge with inp_hit=1 and out_flush=1: EX and MEM valid cleared; WB <= MEM (the branch retires).
- Clock edge with inp_hit=1 and out_stall=1: EX valid cleared (bubble); MEM <= EX; WB <= MEM.
- Otherwise: EX <= ID inputs (valid=inp_id_valid); MEM <= EX; WB <= MEM.
- Forwarding (combinational, from EX tracking): out_fwdA = 01 if EX.useRs & MEM writes EX.rs & ~MEM.memRead; else 10 if EX.useRs & WB writes EX.rs; else 00. MEM has priority over WB. out_fwdB uses rt identically.
- A MEM-stage load never forwards. The load-use stall guarantees the consumer sees the load in WB.
- out_idBypassA = inp_id_useRs & WB writes inp_id_rs; out_idBypassB likewise for rt. This covers the regfile write/read in the same cycle.
- Counters increment by 1 on each clock edge where inp_hit=1 and the respective condition (out_stall / out_flush) holds. They saturate at 2^CNT_W-1 and do not wrap.
- Reset asserted mid-stall or mid-flush: outputs clear immediately; no residual bubble.

Test Plan:
- Reset then add r1,r2,r3 followed by sub r4,r1,r5 -> second instruction in EX sees out_fwdA=01. One cycle later a dependent third instruction sees 10. out_stall stays 0.
- lw r2 then add r3,r2,r4 -> out_stall=1 for exactly one cycle and out_stallCount=1. Consumer then in EX sees out_fwdA=10.
- lw r2 in EX with inp_hit=0 for 3 cycles -> out_stall=0 throughout. Tracking and counters unchanged. Stall occurs on the first hit cycle.
- inp_pcSrc=1 while load-use is pending -> out_flush=1, out_stall=0. Next cycle EX/MEM invalid, fwd=00, out_flushCount=1.
- Destination r0 with useRs on r0, ZERO_REG_HARD=1 -> no stall, fwd=00, no bypass. With ZERO_REG_HARD=0 -> fwd=01.
- CNT_W=2 with 5 consecutive stall events -> out_stallCount reads 1,2,3,3,3. inp_rst pulse returns it to 0 asynchronously.

Source files
------------

// File: rtl/pipe_hazard_unit.sv
// Hazard and forwarding controller for a 5-stage pipeline.
// It tracks the EX/MEM/WB stages, generates load-use stalls, branch flushes and forwarding selects, and counts events.
`timescale 1ns/1ps
module pipe_hazard_unit #(
  parameter int REG_AW        = 3,
  parameter int CNT_W         = 16,
  parameter int ZERO_REG_HARD = 1
) (
  input  logic              inp_clk,
  input  logic              inp_rst,
  input  logic              inp_hit,
  input  logic              inp_pcSrc,
  input  logic              inp_id_valid,
  input  logic [REG_AW-1:0] inp_id_rs,
  input  logic [REG_AW-1:0] inp_id_rt,
  input  logic              inp_id_useRs,
  input  logic              inp_id_useRt,
  input  logic [REG_AW-1:0] inp_id_dest,
  input  logic              inp_id_regWrite,
  input  logic              inp_id_memRead,
  output logic              out_stall,
  output logic              out_flush,
  output logic [1:0]        out_fwdA,
  output logic [1:0]        out_fwdB,
  output logic              out_idBypassA,
  output logic              out_idBypassB,
  output logic [CNT_W-1:0]  out_stallCount,
  output logic [CNT_W-1:0]  out_flushCount
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic              r_ex_valid, r_ex_useRs, r_ex_useRt, r_ex_regWrite, r_ex_memRead;
  logic [REG_AW-1:0] r_ex_rs, r_ex_rt, r_ex_dest;
  logic              r_mem_valid, r_mem_regWrite, r_mem_memRead;
  logic [REG_AW-1:0] r_mem_dest;
  logic              r_wb_valid, r_wb_regWrite, r_wb_memRead;
  logic [REG_AW-1:0] r_wb_dest;
  logic [CNT_W-1:0]  r_stall_cnt, r_flush_cnt;
  logic              w_load_use;

  function automatic logic f_writes(input logic valid, input logic reg_write,
                                    input logic [REG_AW-1:0] dest,
                                    input logic [REG_AW-1:0] r);
    logic zero_ok;
    zero_ok = (ZERO_REG_HARD != 0) ? (dest != {REG_AW{1'b0}}) : 1'b1;
    return valid & reg_write & (dest == r) & zero_ok;
  endfunction

  assign w_load_use = r_ex_memRead &
      ((inp_id_useRs & f_writes(r_ex_valid, r_ex_regWrite, r_ex_dest, inp_id_rs)) |
       (inp_id_useRt & f_writes(r_ex_valid, r_ex_regWrite, r_ex_dest, inp_id_rt)));
  assign out_flush = inp_hit & inp_pcSrc;
  assign out_stall = inp_hit & ~inp_pcSrc & inp_id_valid & w_load_use;

  assign out_idBypassA  = inp_id_useRs & f_writes(r_wb_valid, r_wb_regWrite, r_wb_dest, inp_id_rs);
  assign out_idBypassB  = inp_id_useRt & f_writes(r_wb_valid, r_wb_regWrite, r_wb_dest, inp_id_rt);
  assign out_stallCount = r_stall_cnt;
  assign out_flushCount = r_flush_cnt;

  // A bubble in EX has no operands, so it never requests forwarding.
  always_comb begin
    out_fwdA = 2'b00;
    out_fwdB = 2'b00;
    if (r_ex_valid && r_ex_useRs && !r_mem_memRead &&
        f_writes(r_mem_valid, r_mem_regWrite, r_mem_dest, r_ex_rs)) begin
      out_fwdA = 2'b01;
    end else if (r_ex_valid && r_ex_useRs &&
                 f_writes(r_wb_valid, r_wb_regWrite, r_wb_dest, r_ex_rs)) begin
      out_fwdA = 2'b10;
    end else begin
      out_fwdA = 2'b00;
    end
    if (r_ex_valid && r_ex_useRt && !r_mem_memRead &&
        f_writes(r_mem_valid, r_mem_regWrite, r_mem_dest, r_ex_rt)) begin
      out_fwdB = 2'b01;
    end else if (r_ex_valid && r_ex_useRt &&
                 f_writes(r_wb_valid, r_wb_regWrite, r_wb_dest, r_ex_rt)) begin
      out_fwdB = 2'b10;
    end else begin
      out_fwdB = 2'b00;
    end
  end

  always_ff @(posedge inp_clk or posedge inp_rst) begin
    if (inp_rst) begin
      r_ex_valid     <= 1'b0;
      r_ex_rs        <= '0;
      r_ex_rt        <= '0;
      r_ex_useRs     <= 1'b0;
      r_ex_useRt     <= 1'b0;
      r_ex_dest      <= '0;
      r_ex_regWrite  <= 1'b0;
      r_ex_memRead   <= 1'b0;
      r_mem_valid    <= 1'b0;
      r_mem_dest     <= '0;
      r_mem_regWrite <= 1'b0;
      r_mem_memRead  <= 1'b0;
      r_wb_valid     <= 1'b0;
      r_wb_dest      <= '0;
      r_wb_regWrite  <= 1'b0;
      r_wb_memRead   <= 1'b0;
    end else if (inp_hit) begin
      // WB always takes MEM; on a flush that is the branch itself retiring.
      r_wb_valid    <= r_mem_valid;
      r_wb_dest     <= r_mem_dest;
      r_wb_regWrite <= r_mem_regWrite;
      r_wb_memRead  <= r_mem_memRead;
      if (out_flush) begin
        r_ex_valid  <= 1'b0;
        r_mem_valid <= 1'b0;
      end else begin
        r_mem_valid    <= r_ex_valid;
        r_mem_dest     <= r_ex_dest;
        r_mem_regWrite <= r_ex_regWrite;
        r_mem_memRead  <= r_ex_memRead;
        if (out_stall) begin
          r_ex_valid <= 1'b0;
        end else begin
          r_ex_valid    <= inp_id_valid;
          r_ex_rs       <= inp_id_rs;
          r_ex_rt       <= inp_id_rt;
          r_ex_useRs    <= inp_id_useRs;
          r_ex_useRt    <= inp_id_useRt;
          r_ex_dest     <= inp_id_dest;
          r_ex_regWrite <= inp_id_regWrite;
          r_ex_memRead  <= inp_id_memRead;
        end
      end
    end
  end

  // out_stall and out_flush already include inp_hit, so a miss freezes both counters.
  always_ff @(posedge inp_clk or posedge inp_rst) begin
    if (inp_rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (out_stall && (r_stall_cnt != CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (out_flush && (r_flush_cnt != CNT_MAX)) begin
        r_flush_cnt <= r_flush_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Self-checking bench for pipe_hazard_unit: hand-derived vectors and corner sequences, plus random stimulus against a
// queue-style pipeline model. Two instances share the stimulus: default parameters, and ZERO_REG_HARD=0 with CNT_W=2.
`timescale 1ns/1ps
module tb_pipe_hazard_unit;
  localparam int AW = 3;

  typedef struct packed {
    logic valid; logic [AW-1:0] rs; logic [AW-1:0] rt; logic useRs; logic useRt;
    logic [AW-1:0] dest; logic regWrite; logic memRead;
  } instr_t;
  typedef struct packed { instr_t ex; instr_t mem; instr_t wb; } pipe_t;
  typedef struct packed { logic stall; logic flush; logic [1:0] fwdA; logic [1:0] fwdB; logic bypA; logic bypB; } outs_t;
  typedef struct { logic hit; logic pc; instr_t in; logic [7:0] exp; int scnt; } vec_t;

  logic clk = 1'b0, rst = 1'b1, hit = 1'b1, pcSrc = 1'b0;
  instr_t id = '0;
  logic o0_stall, o0_flush, o0_bA, o0_bB, o1_stall, o1_flush, o1_bA, o1_bB;
  logic [1:0] o0_fA, o0_fB, o1_fA, o1_fB;
  logic [15:0] o0_sc, o0_fc;
  logic [1:0]  o1_sc, o1_fc;

  pipe_t m0, m1;
  int c0s, c0f, c1s, c1f;
  int n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  pipe_hazard_unit #(.REG_AW(AW), .CNT_W(16), .ZERO_REG_HARD(1)) dut0 (
    .inp_clk(clk), .inp_rst(rst), .inp_hit(hit), .inp_pcSrc(pcSrc), .inp_id_valid(id.valid),
    .inp_id_rs(id.rs), .inp_id_rt(id.rt), .inp_id_useRs(id.useRs), .inp_id_useRt(id.useRt),
    .inp_id_dest(id.dest), .inp_id_regWrite(id.regWrite), .inp_id_memRead(id.memRead),
    .out_stall(o0_stall), .out_flush(o0_flush), .out_fwdA(o0_fA), .out_fwdB(o0_fB),
    .out_idBypassA(o0_bA), .out_idBypassB(o0_bB), .out_stallCount(o0_sc), .out_flushCount(o0_fc));

  pipe_hazard_unit #(.REG_AW(AW), .CNT_W(2), .ZERO_REG_HARD(0)) dut1 (
    .inp_clk(clk), .inp_rst(rst), .inp_hit(hit), .inp_pcSrc(pcSrc), .inp_id_valid(id.valid),
    .inp_id_rs(id.rs), .inp_id_rt(id.rt), .inp_id_useRs(id.useRs), .inp_id_useRt(id.useRt),
    .inp_id_dest(id.dest), .inp_id_regWrite(id.regWrite), .inp_id_memRead(id.memRead),
    .out_stall(o1_stall), .out_flush(o1_flush), .out_fwdA(o1_fA), .out_fwdB(o1_fB),
    .out_idBypassA(o1_bA), .out_idBypassB(o1_bB), .out_stallCount(o1_sc), .out_flushCount(o1_fc));

  function automatic instr_t mk(input int rs, input int rt, input int urs, input int urt,
                                input int dest, input int rw, input int mr);
    instr_t i;
    i.valid = 1'b1; i.rs = AW'(rs); i.rt = AW'(rt); i.useRs = urs[0]; i.useRt = urt[0];
    i.dest = AW'(dest); i.regWrite = rw[0]; i.memRead = mr[0];
    return i;
  endfunction

  function automatic logic wr(input instr_t s, input logic [AW-1:0] r, input bit zh);
    return s.valid && s.regWrite && s.dest == r && (!zh || r != '0);
  endfunction

  function automatic logic [1:0] fsel(input pipe_t p, input logic use_r, input logic [AW-1:0] r, input bit zh);
    if (p.ex.valid && use_r && wr(p.mem, r, zh) && !p.mem.memRead) return 2'b01;
    if (p.ex.valid && use_r && wr(p.wb, r, zh)) return 2'b10;
    return 2'b00;
  endfunction

  function automatic outs_t model(input pipe_t p, input bit zh);
    outs_t o;
    o.flush = hit & pcSrc;
    o.stall = hit & !pcSrc & id.valid & p.ex.valid & p.ex.memRead &
              ((id.useRs & wr(p.ex, id.rs, zh)) | (id.useRt & wr(p.ex, id.rt, zh)));
    o.fwdA = fsel(p, p.ex.useRs, p.ex.rs, zh);
    o.fwdB = fsel(p, p.ex.useRt, p.ex.rt, zh);
    o.bypA = id.useRs & wr(p.wb, id.rs, zh);
    o.bypB = id.useRt & wr(p.wb, id.rt, zh);
    return o;
  endfunction

  // Pipeline as a 3-slot queue: EX, MEM, WB. Everything shifts toward WB; bubbles are all-zero slots.
  function automatic pipe_t advance(input pipe_t p, input outs_t o);
    pipe_t n;
    if (!hit) return p;
    n.wb = p.mem;
    if (o.flush) begin n.mem = '0; n.ex = '0; end
    else if (o.stall) begin n.mem = p.ex; n.ex = '0; end
    else begin n.mem = p.ex; n.ex = id; end
    return n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m0 = '0; m1 = '0; c0s = 0; c0f = 0; c1s = 0; c1f = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; model_reset(); #2; rst = 1'b0;
  endtask

  // Compare both DUTs with the model at the falling edge, then clock the model and the DUTs together.
  task automatic step();
    outs_t e0, e1;
    @(negedge clk);
    e0 = model(m0, 1'b1);
    e1 = model(m1, 1'b0);
    chk("dut0 outs", {o0_stall, o0_flush, o0_fA, o0_fB, o0_bA, o0_bB}, e0);
    chk("dut1 outs", {o1_stall, o1_flush, o1_fA, o1_fB, o1_bA, o1_bB}, e1);
    chk("dut0 counts", {o0_sc, o0_fc}, {c0s[15:0], c0f[15:0]});
    chk("dut1 counts", {o1_sc, o1_fc}, {c1s[1:0], c1f[1:0]});
    if (e0.stall && c0s < 65535) c0s++;
    if (e0.flush && c0f < 65535) c0f++;
    if (e1.stall && c1s < 3) c1s++;
    if (e1.flush && c1f < 3) c1f++;
    m0 = advance(m0, e0);
    m1 = advance(m1, e1);
    @(posedge clk); #1;
  endtask

  vec_t tbl[8];
  int exp_sat[5] = '{1, 2, 3, 3, 3};
  instr_t ADD1, SUB4, AND6, OR2, LW2, ADD3, ADD0, SUBR0, RD0, LW0, USE0;

  initial begin
    ADD1 = mk(2, 3, 1, 1, 1, 1, 0);  SUB4 = mk(1, 5, 1, 1, 4, 1, 0);
    AND6 = mk(1, 7, 1, 1, 6, 1, 0);  OR2  = mk(1, 1, 1, 1, 2, 1, 0);
    LW2  = mk(3, 0, 1, 0, 2, 1, 1);  ADD3 = mk(2, 4, 1, 1, 3, 1, 0);
    ADD0 = mk(1, 2, 1, 1, 0, 1, 0);  SUBR0 = mk(0, 5, 1, 0, 4, 1, 0);
    RD0  = mk(0, 0, 1, 1, 7, 0, 0);  LW0  = mk(3, 0, 1, 0, 0, 1, 1);
    USE0 = mk(0, 5, 1, 0, 5, 1, 0);
    // expected bits: {stall, flush, fwdA[1:0], fwdB[1:0], bypA, bypB}
    tbl[0] = '{1'b1, 1'b0, ADD1, 8'b0000_0000, 0};
    tbl[1] = '{1'b1, 1'b0, SUB4, 8'b0000_0000, 0};
    tbl[2] = '{1'b1, 1'b0, AND6, 8'b0001_0000, 0};
    tbl[3] = '{1'b1, 1'b0, OR2,  8'b0010_0011, 0};
    tbl[4] = '{1'b1, 1'b0, LW2,  8'b0000_0000, 0};
    tbl[5] = '{1'b1, 1'b0, ADD3, 8'b1000_0000, 0};
    tbl[6] = '{1'b1, 1'b0, ADD3, 8'b0000_0010, 1};
    tbl[7] = '{1'b1, 1'b0, '0,   8'b0010_0000, 1};

    model_reset();
    #2;
    chk("reset outs", {o0_stall, o0_flush, o0_fA, o0_fB, o0_bA, o0_bB}, 32'd0);
    chk("reset counts", {o0_sc, o0_fc, o1_sc, o1_fc}, 32'd0);
    @(posedge clk); #1; rst = 1'b0;

    // Forwarding chain and load-use stall.
    for (int i = 0; i < 8; i++) begin
      hit = tbl[i].hit; pcSrc = tbl[i].pc; id = tbl[i].in;
      #2;
      chk($sformatf("vec%0d outs", i), {o0_stall, o0_flush, o0_fA, o0_fB, o0_bA, o0_bB}, tbl[i].exp);
      chk($sformatf("vec%0d stallCount", i), o0_sc, tbl[i].scnt);
      step();
    end

    // Cache miss with a load in EX: no stall, nothing moves, until the first hit cycle.
    do_reset(); id = LW2; step();
    hit = 1'b0; id = ADD3;
    for (int k = 0; k < 3; k++) begin
      #2; chk("miss no stall", o0_stall, 1'b0); step();
    end
    chk("miss counter frozen", o0_sc, 16'd0);
    hit = 1'b1; #2; chk("stall after miss", o0_stall, 1'b1); step();
    chk("stall count after miss", o0_sc, 16'd1);

    // A branch taken while load-use is pending flushes instead of stalling.
    do_reset(); id = LW2; step();
    id = ADD3; pcSrc = 1'b1; #2;
    chk("flush over stall", {o0_flush, o0_stall}, 2'b10); step();
    pcSrc = 1'b0; #2;
    chk("post flush", {o0_flush, o0_stall, o0_fA, o0_fB}, 6'd0);
    chk("flush count", o0_fc, 16'd1); step();

    // Register 0: hard-wired in dut0, ordinary in dut1.
    do_reset(); id = ADD0; step(); id = SUBR0; step(); id = RD0; #2;
    chk("r0 fwd dut0", o0_fA, 2'b00); chk("r0 fwd dut1", o1_fA, 2'b01); step();
    #2; chk("r0 bypass dut0", {o0_bA, o0_bB}, 2'b00); chk("r0 bypass dut1", {o1_bA, o1_bB}, 2'b11); step();
    do_reset(); id = LW0; step(); id = USE0; #2;
    chk("r0 stall dut0", o0_stall, 1'b0); chk("r0 stall dut1", o1_stall, 1'b1); step();

    // Saturation of the 2-bit counter, then an asynchronous reset in the middle of a stall.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      id = LW2; step(); id = ADD3; step();
      chk($sformatf("sat event %0d", k), o1_sc, exp_sat[k]);
    end
    id = LW2; step(); id = ADD3; #2;
    chk("pre reset stall", o0_stall, 1'b1);
    rst = 1'b1; #1;
    chk("async reset stall", {o0_stall, o1_stall}, 2'b00);
    chk("async reset counts", {o0_sc, o1_sc}, 32'd0);
    rst = 1'b0; model_reset(); id = '0; step();

    // Random stimulus against the model; a narrow register range keeps hazards frequent.
    for (int k = 0; k < 600; k++) begin
      hit = ($urandom_range(0, 7) != 0);
      pcSrc = ($urandom_range(0, 9) == 0);
      id.valid = ($urandom_range(0, 5) != 0);
      id.rs = AW'($urandom_range(0, 3)); id.rt = AW'($urandom_range(0, 3));
      id.dest = AW'($urandom_range(0, 3));
      id.useRs = 1'($urandom_range(0, 1)); id.useRt = 1'($urandom_range(0, 1));
      id.regWrite = ($urandom_range(0, 3) != 0); id.memRead = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
